// File: rtl/button_debounce_edge_if.sv
// Signal bundle between a raw button source and the debouncer: raw input in,
// conditioned level, edge strobes, toggle, press counter and FSM state out.
interface button_debounce_edge_if #(
    parameter int COUNT_W = 8
);
    logic               btn_in;
    logic               db_out;
    logic               rise;
    logic               fall;
    logic               toggle_q;
    logic [COUNT_W-1:0] press_count;
    logic [1:0]         dbg_state;

    // All outputs are registered level/pulse signals; there is no handshake,
    // a strobe is valid for exactly the one cycle it is high.
    modport master (
        output btn_in,
        input  db_out, rise, fall, toggle_q, press_count, dbg_state
    );

    modport slave (
        input  btn_in,
        output db_out, rise, fall, toggle_q, press_count, dbg_state
    );
endinterface

// File: rtl/button_debounce_edge.sv
// Button conditioner: 2-flop synchronizer, 4-state debounce FSM with a
// stability counter, and registered edge strobes, toggle and press counter.
module button_debounce_edge #(
    parameter int STABLE_CYCLES = 8,
    parameter int COUNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    button_debounce_edge_if.slave  bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    logic               r_s1;
    logic               r_s2;
    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_db;
    logic               r_rise;
    logic               r_fall;
    logic               r_tog;
    logic [COUNT_W-1:0] r_count;

    state_t             w_state_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic               w_rise_nxt;
    logic               w_fall_nxt;
    logic               w_db_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= bus.btn_in;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // cnt holds how many consecutive samples of the new level have been seen.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            LOW: begin
                if (r_s2) begin
                    w_state_nxt = WAIT_HIGH;
                    w_cnt_nxt   = CW'(1);
                end
            end
            WAIT_HIGH: begin
                if (!r_s2) begin
                    w_state_nxt = LOW;
                end else if (r_cnt == LAST) begin
                    w_state_nxt = HIGH;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            HIGH: begin
                if (!r_s2) begin
                    w_state_nxt = WAIT_LOW;
                    w_cnt_nxt   = CW'(1);
                end
            end
            WAIT_LOW: begin
                if (r_s2) begin
                    w_state_nxt = HIGH;
                end else if (r_cnt == LAST) begin
                    w_state_nxt = LOW;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = LOW;
        endcase
        w_db_nxt = (w_state_nxt == HIGH) || (w_state_nxt == WAIT_LOW);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_db    <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_tog   <= 1'b0;
            r_count <= '0;
        end else begin
            r_db   <= w_db_nxt;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
            if (w_rise_nxt) begin
                r_tog   <= ~r_tog;
                r_count <= r_count + COUNT_W'(1);
            end
        end
    end

    assign bus.db_out      = r_db;
    assign bus.rise        = r_rise;
    assign bus.fall        = r_fall;
    assign bus.toggle_q    = r_tog;
    assign bus.press_count = r_count;
    assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_button_debounce_edge.sv
// Bench for button_debounce_edge: three instances (default, 2-bit counter,
// STABLE_CYCLES=2) driven by directed vectors, checked through pulse queues.
module tb_button_debounce_edge;
    typedef struct packed {
        logic [31:0] cyc;
        logic        is_rise;
        logic [7:0]  cnt;
        logic        tog;
    } rec_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    int   ma_cnt;
    bit   ma_tog;
    int   k;

    rec_t q_a[$];
    rec_t q_w[$];
    rec_t q_b[$];

    logic pat[14]      = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int   wrap_cnt[5]  = '{1, 2, 3, 0, 1};
    bit   wrap_tog[5]  = '{1, 0, 1, 0, 1};

    button_debounce_edge_if #(.COUNT_W(8)) a_if ();
    button_debounce_edge_if #(.COUNT_W(2)) w_if ();
    button_debounce_edge_if #(.COUNT_W(8)) b_if ();

    button_debounce_edge #(.STABLE_CYCLES(8), .COUNT_W(8)) dut_a (
        .clk(clk), .reset(rst), .bus(a_if));
    button_debounce_edge #(.STABLE_CYCLES(8), .COUNT_W(2)) dut_w (
        .clk(clk), .reset(rst), .bus(w_if));
    button_debounce_edge #(.STABLE_CYCLES(2), .COUNT_W(8)) dut_b (
        .clk(clk), .reset(rst), .bus(b_if));

    // clock / reset and cycle count
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: pulse seen with no expected entry (cycle %0d)", name, cyc);
    endtask

    task automatic push(input int inst, input int c, input bit r, input int cnt, input bit tog);
        rec_t e;
        e.cyc     = c;
        e.is_rise = r;
        e.cnt     = 8'(cnt);
        e.tog     = tog;
        case (inst)
            0:       q_a.push_back(e);
            1:       q_w.push_back(e);
            default: q_b.push_back(e);
        endcase
    endtask

    task automatic a_rise(input int c);
        ma_cnt = (ma_cnt + 1) % 256;
        ma_tog = ~ma_tog;
        push(0, c, 1'b1, ma_cnt, ma_tog);
    endtask

    task automatic a_fall(input int c);
        push(0, c, 1'b0, ma_cnt, ma_tog);
    endtask

    task automatic check_pulse(input string tag, input rec_t e, input logic r, input logic f,
                               input logic db, input logic tog, input int cnt);
        cmp({tag, "_pulse_cycle"}, cyc, int'(e.cyc));
        cmp({tag, "_rise"}, int'(r), int'(e.is_rise));
        cmp({tag, "_fall"}, int'(f), int'(!e.is_rise));
        cmp({tag, "_db_out"}, int'(db), int'(e.is_rise));
        cmp({tag, "_toggle_q"}, int'(tog), int'(e.tog));
        cmp({tag, "_press_count"}, cnt, int'(e.cnt));
    endtask

    task automatic check_zero(input string tag, input logic db, input logic r, input logic f,
                              input logic tog, input int cnt, input int st);
        cmp({tag, "_db_out"}, int'(db), 0);
        cmp({tag, "_rise"}, int'(r), 0);
        cmp({tag, "_fall"}, int'(f), 0);
        cmp({tag, "_toggle_q"}, int'(tog), 0);
        cmp({tag, "_press_count"}, cnt, 0);
        cmp({tag, "_state"}, st, 0);
    endtask

    // scoreboard monitors: every strobe must match the head of its queue
    always @(negedge clk) begin
        if (!rst && (a_if.rise || a_if.fall)) begin
            if (q_a.size() == 0) unexpected("a_unexpected");
            else check_pulse("a", q_a.pop_front(), a_if.rise, a_if.fall, a_if.db_out,
                             a_if.toggle_q, int'(a_if.press_count));
        end
    end

    always @(negedge clk) begin
        if (!rst && (w_if.rise || w_if.fall)) begin
            if (q_w.size() == 0) unexpected("w_unexpected");
            else check_pulse("w", q_w.pop_front(), w_if.rise, w_if.fall, w_if.db_out,
                             w_if.toggle_q, int'(w_if.press_count));
        end
    end

    always @(negedge clk) begin
        if (!rst && (b_if.rise || b_if.fall)) begin
            if (q_b.size() == 0) unexpected("b_unexpected");
            else check_pulse("b", q_b.pop_front(), b_if.rise, b_if.fall, b_if.db_out,
                             b_if.toggle_q, int'(b_if.press_count));
        end
    end

    // directed stimulus
    initial begin
        checks = 0;
        errors = 0;
        ma_cnt = 0;
        ma_tog = 1'b0;
        rst = 1'b1;
        a_if.btn_in = 1'b1;
        w_if.btn_in = 1'b0;
        b_if.btn_in = 1'b0;
        step(3);
        check_zero("rst_hold", a_if.db_out, a_if.rise, a_if.fall, a_if.toggle_q,
                   int'(a_if.press_count), int'(a_if.dbg_state));

        // button already held when reset releases: a full-latency press
        rst = 1'b0;
        a_rise(cyc + 10);
        step(5);
        cmp("rst_release_db_early", int'(a_if.db_out), 0);
        step(15);

        a_if.btn_in = 1'b0;
        a_fall(cyc + 10);
        step(20);

        // clean press then release
        a_if.btn_in = 1'b1;
        a_rise(cyc + 10);
        step(20);
        a_if.btn_in = 1'b0;
        a_fall(cyc + 10);
        step(20);
        cmp("clean_state_low", int'(a_if.dbg_state), 0);

        // bounce: only the run of eight highs qualifies
        k = cyc;
        a_rise(k + 15);
        for (int i = 0; i < 14; i++) begin
            a_if.btn_in = pat[i];
            step(1);
        end
        a_if.btn_in = 1'b1;
        step(20);
        cmp("bounce_db_high", int'(a_if.db_out), 1);
        cmp("bounce_state_high", int'(a_if.dbg_state), 2);
        a_if.btn_in = 1'b0;
        a_fall(cyc + 10);
        step(20);

        // 2-bit press counter wrap
        for (int i = 0; i < 5; i++) begin
            w_if.btn_in = 1'b1;
            push(1, cyc + 10, 1'b1, wrap_cnt[i], wrap_tog[i]);
            step(20);
            w_if.btn_in = 1'b0;
            push(1, cyc + 10, 1'b0, wrap_cnt[i], wrap_tog[i]);
            step(20);
        end

        // STABLE_CYCLES=2: one-cycle glitch ignored, two-cycle pulse accepted
        b_if.btn_in = 1'b1;
        step(1);
        b_if.btn_in = 1'b0;
        step(10);
        cmp("glitch_db_out", int'(b_if.db_out), 0);
        cmp("glitch_state", int'(b_if.dbg_state), 0);
        cmp("glitch_press_count", int'(b_if.press_count), 0);
        k = cyc;
        b_if.btn_in = 1'b1;
        push(2, k + 4, 1'b1, 1, 1'b1);
        step(2);
        b_if.btn_in = 1'b0;
        push(2, k + 6, 1'b0, 1, 1'b1);
        step(10);

        // reset while counting towards a press
        a_if.btn_in = 1'b1;
        step(7);
        cmp("mid_wait_high", int'(a_if.dbg_state), 1);
        rst = 1'b1;
        #1;
        check_zero("mid_rst", a_if.db_out, a_if.rise, a_if.fall, a_if.toggle_q,
                   int'(a_if.press_count), int'(a_if.dbg_state));
        ma_cnt = 0;
        ma_tog = 1'b0;
        step(3);
        rst = 1'b0;
        a_rise(cyc + 10);
        step(20);

        step(5);
        cmp("a_pending", q_a.size(), 0);
        cmp("w_pending", q_w.size(), 0);
        cmp("b_pending", q_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
